// File: rtl/radix4_booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Optional build macro: RADIX4_BOOTH_EARLY_TERM_EN (used by radix4_booth_mult_seq).
package radix4_booth_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  // 3-bit Booth groups {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] GrpZero0 = 3'b000;
  localparam logic [2:0] GrpP1Lo  = 3'b001;
  localparam logic [2:0] GrpP1Hi  = 3'b010;
  localparam logic [2:0] GrpP2    = 3'b011;
  localparam logic [2:0] GrpM2    = 3'b100;
  localparam logic [2:0] GrpM1Lo  = 3'b101;
  localparam logic [2:0] GrpM1Hi  = 3'b110;
  localparam logic [2:0] GrpZero1 = 3'b111;

  // Selected Booth digit
  typedef enum logic [2:0] {
    DigZero,
    DigP1,
    DigM1,
    DigP2,
    DigM2
  } digit_e;

  // Number of Booth iterations for an even operand width
  function automatic int unsigned n_iter(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Recode one Booth group into its digit
  function automatic digit_e booth_digit(input logic [2:0] grp);
    digit_e dig;
    case (grp)
      GrpZero0, GrpZero1: dig = DigZero;
      GrpP1Lo, GrpP1Hi:   dig = DigP1;
      GrpP2:              dig = DigP2;
      GrpM2:              dig = DigM2;
      GrpM1Lo, GrpM1Hi:   dig = DigM1;
      default:            dig = DigZero;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/radix4_booth_pp_sel.sv
// Radix-4 Booth partial-product selector: maps one 3-bit group and the extended
// multiplicand to a sign-extended, unshifted 2*WIDTH partial product.
module radix4_booth_pp_sel #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]         group,
  input  logic [WIDTH+1:0]   a_ext,
  output logic [2*WIDTH-1:0] pp
);
  import radix4_booth_pkg::*;

  digit_e           digit;
  logic [WIDTH+1:0] a_x2;
  logic [WIDTH+1:0] sel;

  // 2A cannot overflow: a_ext already carries two guard bits
  assign a_x2 = {a_ext[WIDTH:0], 1'b0};

  // Pick 0, +-A or +-2A at WIDTH+2 bits
  always_comb begin
    digit = booth_digit(group);
    sel   = '0;
    unique case (digit)
      DigZero: sel = '0;
      DigP1:   sel = a_ext;
      DigM1:   sel = -a_ext;
      DigP2:   sel = a_x2;
      DigM2:   sel = -a_x2;
      default: sel = '0;
    endcase
  end

  assign pp = {{(WIDTH - 2){sel[WIDTH+1]}}, sel};

endmodule

// File: rtl/radix4_booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock, with a
// start/busy/done handshake and runtime signed/unsigned mode.
// Optional macro RADIX4_BOOTH_EARLY_TERM_EN: finish as soon as every remaining
// Booth group is known to contribute zero.
module radix4_booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);
  import radix4_booth_pkg::*;

  localparam int unsigned N_ITER = n_iter(WIDTH);
  localparam int unsigned CntW   = $clog2(N_ITER);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_ITER - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("radix4_booth_mult_seq: WIDTH must be even and >= 4");
  end

  state_e               state_q;
  logic [WIDTH+1:0]     a_q;     // extended multiplicand
  logic [WIDTH+2:0]     mb_q;    // extended multiplier, shifted right 2 per iteration
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;

  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_sh;
  logic [WIDTH+2:0]     mb_next;
  logic                 last_iter;
  logic                 ext_a;
  logic                 ext_b;

  assign ext_a = is_signed & a[WIDTH-1];
  assign ext_b = is_signed & b[WIDTH-1];

  radix4_booth_pp_sel #(
    .WIDTH(WIDTH)
  ) u_pp_sel (
    .group(mb_q[2:0]),
    .a_ext(a_q),
    .pp   (pp)
  );

  // Align the partial product, advance the multiplier window, decide on the last step
  always_comb begin
    pp_sh     = pp << {cnt_q, 1'b0};
    mb_next   = {{2{mb_q[WIDTH+2]}}, mb_q[WIDTH+2:2]};
    last_iter = (cnt_q == LastCnt);
`ifdef RADIX4_BOOTH_EARLY_TERM_EN
    // mb_next[0] is the overlap bit shared with the next group, so it must
    // match the upper bits too; only then do all remaining groups decode to 0.
    if ((mb_next == '0) || (mb_next == '1)) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Controller, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= {{2{ext_a}}, a};
            mb_q    <= {{2{ext_b}}, b, 1'b0};
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_q + pp_sh;
          mb_q  <= mb_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          result  <= acc_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_booth_mult_seq.sv
// Directed bench for radix4_booth_mult_seq: WIDTH=32 handshake/product cases and
// a WIDTH=8 operand sweep against a behavioural product.
module tb_radix4_booth_mult_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  logic        start8;
  logic        sgn8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] result8;

  int total = 0;
  int bad   = 0;

  radix4_booth_mult_seq #(
    .WIDTH(32)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  radix4_booth_mult_seq #(
    .WIDTH(8)
  ) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .is_signed(sgn8),
    .a        (a8),
    .b        (b8),
    .busy     (busy8),
    .done     (done8),
    .result   (result8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected cycles from start edge to done, following the termination rule
  function automatic int exp_lat(input int w, input logic s, input logic [31:0] bv);
    int n;
    n = w / 2 + 1;
`ifdef RADIX4_BOOTH_EARLY_TERM_EN
    begin
      logic [34:0] mb;
      logic        ext;
      logic        same;
      ext = s & bv[w-1];
      mb  = {35{ext}};
      mb[0] = 1'b0;
      for (int k = 0; k < w; k++) mb[k+1] = bv[k];
      for (int i = 0; i < n; i++) begin
        same = 1'b1;
        for (int j = 2 * i + 2; j < 35; j++) if (mb[j] != ext) same = 1'b0;
        if (same) return i + 2;
      end
    end
`else
    if (s === 1'bx || bv === 'x) return -1;
`endif
    return n + 1;
  endfunction

  // Called #1 after a rising edge; returns #1 after the done edge (or timeout)
  task automatic run32(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       output logic [63:0] res, output int lat);
    is_signed = s;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic run8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                      output logic [15:0] res, output int lat);
    sgn8 = s;
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result8;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    logic [15:0] res8;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic [15:0] ref8;
    logic [7:0]  vals [16];
    int lat;
    int done_cnt;
    int done_cyc;
    int early_low;

    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    start8 = 1'b0;
    sgn8 = 1'b0;
    a8 = '0;
    b8 = '0;

    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Signed 7 * -3
    run32(1'b1, 32'd7, 32'hFFFF_FFFD, res, lat);
    check("s_7_m3_result", res, 64'hFFFF_FFFF_FFFF_FFEB);
    check("s_7_m3_latency", 64'(lat), 64'(exp_lat(32, 1'b1, 32'hFFFF_FFFD)));
    check("s_7_m3_busy_at_done", 64'(busy), 64'd0);

    // Result held and done single-cycle
    held = result;
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", result, held);
    check("done_single_pulse", 64'(done), 64'd0);

    // Signed most-negative squared
    run32(1'b1, 32'h8000_0000, 32'h8000_0000, res, lat);
    check("s_min_sq_result", res, 64'h4000_0000_0000_0000);

    // Unsigned all-ones squared, then same operands signed
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("u_ff_sq_result", res, 64'hFFFF_FFFE_0000_0001);
    check("u_ff_sq_latency", 64'(lat), 64'(exp_lat(32, 1'b0, 32'hFFFF_FFFF)));
    // Back-to-back: start sampled on the cycle after done
    run32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("b2b_s_m1_sq_result", res, 64'h0000_0000_0000_0001);
    check("b2b_s_m1_sq_latency", 64'(lat), 64'(exp_lat(32, 1'b1, 32'hFFFF_FFFF)));

    // Early-termination candidates (fixed latency in the default build)
    run32(1'b1, 32'd3, 32'd5, res, lat);
    check("s_3_5_result", res, 64'd15);
    check("s_3_5_latency", 64'(lat), 64'(exp_lat(32, 1'b1, 32'd5)));
    run32(1'b1, 32'd3, 32'd0, res, lat);
    check("s_3_0_result", res, 64'd0);
    check("s_3_0_latency", 64'(lat), 64'(exp_lat(32, 1'b1, 32'd0)));

    // Extra starts during the operation are ignored
    is_signed = 1'b1;
    a = 32'd7;
    b = 32'hFFFF_FFFD;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    done_cyc = 0;
    early_low = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 9) begin
        start = 1'b1;
        a = 32'd1;
        b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        held = result;
      end else if (busy !== 1'b1 && done_cnt == 0) begin
        early_low = 1;
      end
    end
    start = 1'b0;
    check("hs_done_count", 64'(done_cnt), 64'd1);
    check("hs_done_cycle", 64'(done_cyc), 64'(exp_lat(32, 1'b1, 32'hFFFF_FFFD)));
    check("hs_busy_early_low", 64'(early_low), 64'd0);
    check("hs_result", held, 64'hFFFF_FFFF_FFFF_FFEB);

    // Asynchronous reset mid-operation
    is_signed = 1'b1;
    a = 32'h0001_0000;
    b = 32'h7FFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run32(1'b1, 32'd2, 32'd3, res, lat);
    check("after_rst_result", res, 64'd6);
    check("after_rst_latency", 64'(lat), 64'(exp_lat(32, 1'b1, 32'd3)));

    // WIDTH=8 sweep over boundary-heavy operand set
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h33, 8'h40, 8'h55,
             8'h7E, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC0, 8'hFE, 8'hFF};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          if (m == 1) begin
            sa = {{8{vals[i][7]}}, vals[i]};
            sb = {{8{vals[j][7]}}, vals[j]};
          end else begin
            sa = {8'h00, vals[i]};
            sb = {8'h00, vals[j]};
          end
          ref8 = sa * sb;
          run8(m[0], vals[i], vals[j], res8, lat);
          check($sformatf("w8_%0d_%h_%h_result", m, vals[i], vals[j]), 64'(res8), 64'(ref8));
          check($sformatf("w8_%0d_%h_%h_latency", m, vals[i], vals[j]), 64'(lat),
                64'(exp_lat(8, m[0], {24'h0, vals[j]})));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
